// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random pre-stimulus delay, lamp, ms measurement,
// false-start and timeout detection. Upstream LFSR is frozen only while seeding.
module reaction_timer_ctrl #(
   parameter int unsigned CLKS_PER_MS  = 50000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned DELAY_SHIFT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        react,
   input  logic [7:0]  rand_val,
   input  logic        rand_valid,
   output logic        lfsr_stop,
   output logic        led,
   output logic [13:0] result_ms,
   output logic        done,
   output logic        false_start,
   output logic        timeout
);

   localparam int unsigned MS_W    = 14;
   localparam int unsigned MS_MAX  = 9999;
   localparam int unsigned PS_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam int unsigned DLY_MAX = MIN_DELAY_MS + (255 << DELAY_SHIFT);
   localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEED  = 3'd1,
      S_WAIT  = 3'd2,
      S_GO    = 3'd3,
      S_DONE  = 3'd4,
      S_FALSE = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              start_q, react_q;
   logic [PS_W-1:0]   ps_q, ps_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic [MS_W-1:0]   ms_q, ms_d;
   logic [MS_W-1:0]   result_d;
   logic              lfsr_stop_d, led_d, done_d, false_start_d, timeout_d;
   logic              start_press, react_press, timing, tick;

   // Button presses are rising edges against the previous registered sample.
   assign start_press = start & ~start_q;
   assign react_press = react & ~react_q;

   assign timing = (state_q == S_WAIT) || (state_q == S_GO);
   assign tick   = timing && (ps_q == PS_W'(CLKS_PER_MS - 1));

   // Next-state, counters and registered-output next values.
   always_comb begin
      state_d       = state_q;
      ps_d          = '0;
      dly_d         = dly_q;
      ms_d          = ms_q;
      result_d      = result_ms;
      done_d        = done;
      false_start_d = false_start;
      timeout_d     = timeout;

      if (timing && !tick) begin
         ps_d = ps_q + PS_W'(1);
      end

      case (state_q)
         S_IDLE, S_DONE, S_FALSE: begin
            if (start_press) begin
               state_d       = S_SEED;
               result_d      = '0;
               done_d        = 1'b0;
               false_start_d = 1'b0;
               timeout_d     = 1'b0;
            end
         end
         S_SEED: begin
            if (rand_valid) begin
               dly_d   = DLY_W'(MIN_DELAY_MS) + (DLY_W'(rand_val) << DELAY_SHIFT);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A premature press outranks a tick landing in the same cycle.
            if (react_press) begin
               state_d       = S_FALSE;
               false_start_d = 1'b1;
               ps_d          = '0;
            end else if (tick) begin
               if (dly_q == DLY_W'(1)) begin
                  state_d = S_GO;
                  ms_d    = '0;
               end else begin
                  dly_d = dly_q - DLY_W'(1);
               end
            end
         end
         S_GO: begin
            if (react_press) begin
               result_d = ms_q;
               done_d   = 1'b1;
               state_d  = S_DONE;
               ps_d     = '0;
            end else if (tick) begin
               if (ms_q == MS_W'(MS_MAX - 1)) begin
                  result_d  = MS_W'(MS_MAX);
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  ms_d = ms_q + MS_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      lfsr_stop_d = (state_d == S_SEED);
      led_d       = (state_d == S_GO);
   end

   // State, counters, edge-detector samples and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b1;
         react_q     <= 1'b1;
         ps_q        <= '0;
         dly_q       <= '0;
         ms_q        <= '0;
         lfsr_stop   <= 1'b0;
         led         <= 1'b0;
         result_ms   <= '0;
         done        <= 1'b0;
         false_start <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start;
         react_q     <= react;
         ps_q        <= ps_d;
         dly_q       <= dly_d;
         ms_q        <= ms_d;
         lfsr_stop   <= lfsr_stop_d;
         led         <= led_d;
         result_ms   <= result_d;
         done        <= done_d;
         false_start <= false_start_d;
         timeout     <= timeout_d;
      end
   end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed + randomized bench for reaction_timer_ctrl; expectations come from
// delay/tick arithmetic on the game rules, not from the controller structure.
module tb_reaction_timer_ctrl;

   localparam int CLKS  = 4;
   localparam int MIN   = 2;
   localparam int SHIFT = 0;
   localparam int MSMAX = 9999;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        react;
   logic [7:0]  rand_val;
   logic        rand_valid;
   logic        lfsr_stop;
   logic        led;
   logic [13:0] result_ms;
   logic        done;
   logic        false_start;
   logic        timeout;

   int n_checks = 0;
   int n_fail   = 0;

   reaction_timer_ctrl #(
      .CLKS_PER_MS (CLKS),
      .MIN_DELAY_MS(MIN),
      .DELAY_SHIFT (SHIFT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .react      (react),
      .rand_val   (rand_val),
      .rand_valid (rand_valid),
      .lfsr_stop  (lfsr_stop),
      .led        (led),
      .result_ms  (result_ms),
      .done       (done),
      .false_start(false_start),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   // Pre-stimulus delay in ms for a given random byte.
   function automatic int delay_ms(input int r);
      return MIN + (r << SHIFT);
   endfunction

   // Reading for a press seen j cycles after the lamp lit: whole ms elapsed.
   function automatic int expected_result(input int j);
      int m;
      m = j / CLKS;
      return (m >= MSMAX) ? MSMAX : m;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to_wait(input int r, input int lat, input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_seed_stop"},  32'(lfsr_stop),   32'd1);
      check({tag, "_clr_done"},   32'(done),        32'd0);
      check({tag, "_clr_result"}, 32'(result_ms),   32'd0);
      check({tag, "_clr_fs"},     32'(false_start), 32'd0);
      check({tag, "_clr_to"},     32'(timeout),     32'd0);
      for (int i = 0; i < lat; i++) begin
         step();
         check({tag, "_seed_hold"}, 32'(lfsr_stop), 32'd1);
      end
      rand_val   = 8'(r);
      rand_valid = 1'b1;
      step();
      rand_valid = 1'b0;
      check({tag, "_wait_stop"}, 32'(lfsr_stop), 32'd0);
      check({tag, "_wait_led"},  32'(led),       32'd0);
   endtask

   task automatic wait_led(input int d, input string tag);
      int lat;
      lat = -1;
      for (int i = 1; i <= d * CLKS + 8; i++) begin
         step();
         if (led === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({tag, "_led_latency"}, 32'(lat), 32'(d * CLKS));
   endtask

   task automatic react_after(input int j, input int start_at, input string tag);
      check({tag, "_led_on"}, 32'(led), 32'd1);
      for (int i = 0; i < j; i++) begin
         start = (i == start_at);
         step();
      end
      start = 1'b0;
      react = 1'b1;
      step();
      react = 1'b0;
      check({tag, "_done"},    32'(done),      32'd1);
      check({tag, "_result"},  32'(result_ms), 32'(expected_result(j)));
      check({tag, "_led_off"}, 32'(led),       32'd0);
      check({tag, "_timeout"}, 32'(timeout),   32'd0);
   endtask

   task automatic false_run(input int r, input int lat, input int k, input string tag);
      int lit;
      run_to_wait(r, lat, tag);
      lit = 0;
      for (int i = 0; i < k; i++) begin
         step();
         if (led === 1'b1) lit = 1;
      end
      react = 1'b1;
      step();
      react = 1'b0;
      check({tag, "_fs"},   32'(false_start), 32'd1);
      check({tag, "_done"}, 32'(done),        32'd0);
      for (int i = 0; i < 2 * delay_ms(r) * CLKS + 4; i++) begin
         step();
         if (led !== 1'b0) lit = 1;
      end
      check({tag, "_led_never"}, 32'(lit), 32'd0);
      check({tag, "_fs_hold"},   32'(false_start), 32'd1);
   endtask

   initial begin
      int r, lat, d, j, n;

      // Buttons held through reset must not count as presses.
      reset      = 1'b1;
      start      = 1'b1;
      react      = 1'b1;
      rand_val   = 8'd0;
      rand_valid = 1'b0;
      repeat (3) step();
      check("rst_lfsr_stop", 32'(lfsr_stop),   32'd0);
      check("rst_led",       32'(led),         32'd0);
      check("rst_result",    32'(result_ms),   32'd0);
      check("rst_done",      32'(done),        32'd0);
      check("rst_fs",        32'(false_start), 32'd0);
      check("rst_timeout",   32'(timeout),     32'd0);
      reset = 1'b0;
      repeat (3) step();
      check("held_start_lfsr", 32'(lfsr_stop),   32'd0);
      check("held_react_fs",   32'(false_start), 32'd0);
      start = 1'b0;
      react = 1'b0;
      step();

      // React in IDLE is ignored.
      react = 1'b1;
      step();
      react = 1'b0;
      step();
      check("idle_react_fs",   32'(false_start), 32'd0);
      check("idle_react_done", 32'(done),        32'd0);
      check("idle_react_led",  32'(led),         32'd0);

      // Normal run with a start press during GO.
      run_to_wait(3, 1, "normal");
      wait_led(delay_ms(3), "normal");
      react_after(10, 4, "normal");

      // React in DONE is ignored.
      react = 1'b1;
      step();
      react = 1'b0;
      step();
      check("done_react_done",   32'(done),      32'd1);
      check("done_react_result", 32'(result_ms), 32'd2);

      // Press lands on the tick that would make the count 8.
      run_to_wait(1, 0, "collide");
      wait_led(delay_ms(1), "collide");
      react_after(31, -1, "collide");

      // Press right after the lamp lights reads zero.
      run_to_wait(0, 2, "instant");
      wait_led(delay_ms(0), "instant");
      react_after(0, -1, "instant");

      false_run(0, 0, 5, "false5");
      false_run(5, 1, delay_ms(5) * CLKS - 1, "false_edge");

      for (int round = 0; round < 10; round++) begin
         r   = int'($urandom_range(0, 255));
         lat = int'($urandom_range(0, 3));
         d   = delay_ms(r);
         if ($urandom_range(0, 2) == 0) begin
            false_run(r, lat, int'($urandom_range(0, d * CLKS - 1)), "rnd_false");
         end else begin
            run_to_wait(r, lat, "rnd");
            wait_led(d, "rnd");
            j = int'($urandom_range(0, 60));
            react_after(j, -1, "rnd");
         end
      end

      // Asynchronous reset while the lamp is lit, react held across it.
      run_to_wait(2, 0, "midrst");
      wait_led(delay_ms(2), "midrst");
      step();
      step();
      react = 1'b1;
      #1 reset = 1'b1;
      #1;
      check("midrst_led",       32'(led),         32'd0);
      check("midrst_lfsr_stop", 32'(lfsr_stop),   32'd0);
      check("midrst_done",      32'(done),        32'd0);
      check("midrst_result",    32'(result_ms),   32'd0);
      check("midrst_fs",        32'(false_start), 32'd0);
      check("midrst_timeout",   32'(timeout),     32'd0);
      step();
      step();
      reset = 1'b0;
      repeat (3) step();
      check("postrst_led",  32'(led),  32'd0);
      check("postrst_done", 32'(done), 32'd0);
      run_to_wait(0, 0, "postrst");
      repeat (4) step();
      check("postrst_held_react_fs", 32'(false_start), 32'd0);
      react = 1'b0;
      step();
      react = 1'b1;
      step();
      react = 1'b0;
      check("postrst_press_fs", 32'(false_start), 32'd1);

      // No reaction: gives up on the tick that would reach 9999 ms.
      run_to_wait(0, 0, "tmo");
      wait_led(delay_ms(0), "tmo");
      n = -1;
      for (int i = 1; i <= MSMAX * CLKS + 8; i++) begin
         step();
         if (done === 1'b1) begin
            n = i;
            break;
         end
      end
      check("tmo_latency", 32'(n),         32'(MSMAX * CLKS));
      check("tmo_result",  32'(result_ms), 32'(MSMAX));
      check("tmo_timeout", 32'(timeout),   32'd1);
      check("tmo_led",     32'(led),       32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
